// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg -- shared types and constants for the six-digit multiplexed
// 7-segment scanner (seg_scan, seg_scan_timer, seg_scan_if).
//   NUM_DIGITS : number of multiplexed digits
//   bcd_t      : one BCD nibble
//   digits_t   : six packed nibbles, digit 0 in [3:0]
//   idx_t      : digit slot index
//   DIG_OFF    : active-low digit enable with every digit off
//   get_nibble : selects nibble i from a digits_t word
package seg_scan_pkg;

  localparam int unsigned NUM_DIGITS = 6;

  typedef logic [3:0]              bcd_t;
  typedef logic [NUM_DIGITS*4-1:0] digits_t;
  typedef logic [2:0]              idx_t;

  localparam logic [NUM_DIGITS-1:0] DIG_OFF = 6'b111111;

  function automatic bcd_t get_nibble(digits_t d, idx_t i);
    return d[{i, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/seg_scan_if.sv
// seg_scan_if -- display data / scan output bundle of seg_scan.
//   digits_in   : six BCD nibbles to display (master -> slave)
//   load        : one-cycle strobe capturing digits_in (master -> slave)
//   bcd_out     : nibble of the digit currently scanned (slave -> master)
//   dig_sel     : active-low one-hot digit enable (slave -> master)
//   frame_start : pulse on the first digit-0 cycle of a frame (slave -> master)
interface seg_scan_if;
  import seg_scan_pkg::*;

  digits_t                digits_in;
  logic                   load;
  bcd_t                   bcd_out;
  logic [NUM_DIGITS-1:0]  dig_sel;
  logic                   frame_start;

  modport master (
    output digits_in, load,
    input  bcd_out, dig_sel, frame_start
  );

  modport slave (
    input  digits_in, load,
    output bcd_out, dig_sel, frame_start
  );
endinterface

// File: rtl/seg_scan_timer.sv
// seg_scan_timer -- prescaler and digit slot counter for seg_scan.
//   clk_i        : clock
//   rst_i        : synchronous active-high reset
//   dead_o       : prescaler is inside the blanking window (p < DEAD_CYC)
//   slot_start_o : first cycle of a slot (p == 0)
//   slot_end_o   : last cycle of a slot (p == CLK_DIV-1)
//   idx_o        : current slot index 0..NUM_DIGITS-1
module seg_scan_timer
  import seg_scan_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 50000,
  parameter int unsigned DEAD_CYC = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic dead_o,
  output logic slot_start_o,
  output logic slot_end_o,
  output idx_t idx_o
);

  localparam int unsigned PW = $clog2(CLK_DIV);

  logic [PW-1:0] p_q, p_d;
  idx_t          idx_q, idx_d;

  assign slot_end_o   = (p_q == PW'(CLK_DIV - 1));
  assign slot_start_o = (p_q == '0);
  assign dead_o       = (p_q < PW'(DEAD_CYC));
  assign idx_o        = idx_q;

  always_comb begin
    p_d   = p_q + 1'b1;
    idx_d = idx_q;
    if (slot_end_o) begin
      p_d = '0;
      if (idx_q == idx_t'(NUM_DIGITS - 1)) idx_d = '0;
      else                                 idx_d = idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      p_q   <= '0;
      idx_q <= '0;
    end else begin
      p_q   <= p_d;
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/seg_scan.sv
// seg_scan -- six-digit time-multiplexed BCD display scanner.
//   clk  : clock, all state changes on its rising edge
//   rst  : synchronous active-high reset
//   bus  : seg_scan_if.slave (digits_in, load, bcd_out, dig_sel, frame_start)
// Parameters: CLK_DIV cycles per digit slot, DEAD_CYC blanking cycles at the
// start of each slot.
// Build option: define SEG_SCAN_LZB_EN for leading-zero blanking of digits
// 5..1; without it every digit is always displayed.
// New data is staged in a shadow register and swapped into the active
// register only at the frame boundary, so a frame never mixes old and new data.
module seg_scan
  import seg_scan_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 50000,
  parameter int unsigned DEAD_CYC = 16
) (
  input  logic      clk,
  input  logic      rst,
  seg_scan_if.slave bus
);

  logic dead, slot_start, slot_end;
  idx_t idx;

  seg_scan_timer #(
    .CLK_DIV  (CLK_DIV),
    .DEAD_CYC (DEAD_CYC)
  ) u_timer (
    .clk_i        (clk),
    .rst_i        (rst),
    .dead_o       (dead),
    .slot_start_o (slot_start),
    .slot_end_o   (slot_end),
    .idx_o        (idx)
  );

  digits_t               active_q, active_d;
  digits_t               shadow_q, shadow_d;
  logic                  pending_q, pending_d;
  bcd_t                  bcd_q, bcd_d;
  logic [NUM_DIGITS-1:0] sel_q, sel_d;
  logic                  fs_q, fs_d;
  logic [NUM_DIGITS-1:0] blank;
  logic                  wrap;

  assign wrap = slot_end && (idx == idx_t'(NUM_DIGITS - 1));

  // Leading-zero blanking: walk from the top digit down, a digit stays
  // blanked only while it and every digit above it are zero.
  always_comb begin
`ifdef SEG_SCAN_LZB_EN
    logic hi_zero;
    hi_zero = 1'b1;
`endif
    blank = '0;
`ifdef SEG_SCAN_LZB_EN
    for (int unsigned i = NUM_DIGITS - 1; i >= 1; i--) begin
      hi_zero  = hi_zero && (active_q[i*4 +: 4] == 4'd0);
      blank[i] = hi_zero;
    end
`endif
  end

  // Shadow/active staging; a load on the wrap cycle bypasses the shadow.
  always_comb begin
    active_d  = active_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    if (bus.load && wrap) begin
      active_d  = bus.digits_in;
      shadow_d  = bus.digits_in;
      pending_d = 1'b0;
    end else if (bus.load) begin
      shadow_d  = bus.digits_in;
      pending_d = 1'b1;
    end else if (wrap && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
  end

  // Outputs are registered from the current p/idx/active, so they trail the
  // counters by one clock; active swaps on the same edge idx returns to 0.
  always_comb begin
    bcd_d = blank[idx] ? 4'd0 : get_nibble(active_q, idx);
    sel_d = (dead || blank[idx]) ? DIG_OFF
                                 : ~(NUM_DIGITS'(1) << idx);
    fs_d  = slot_start && (idx == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q  <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      bcd_q     <= 4'd0;
      sel_q     <= DIG_OFF;
      fs_q      <= 1'b0;
    end else begin
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      bcd_q     <= bcd_d;
      sel_q     <= sel_d;
      fs_q      <= fs_d;
    end
  end

  assign bus.bcd_out     = bcd_q;
  assign bus.dig_sel     = sel_q;
  assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan -- scoreboard bench for seg_scan (CLK_DIV=8, DEAD_CYC=2).
// A reference model advances once per clock from the cycle count since
// reset and pushes the expected display outputs; a monitor pops and compares
// them on the falling edge. Honours SEG_SCAN_LZB_EN like the design.
module tb_seg_scan;

  localparam int unsigned CD    = 8;
  localparam int unsigned DC    = 2;
  localparam int unsigned ND    = 6;
  localparam int unsigned FRAME = CD * ND;

  logic clk = 1'b0;
  logic rst = 1'b1;

  seg_scan_if bus();

  seg_scan #(.CLK_DIV(CD), .DEAD_CYC(DC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] bcd;
    logic [5:0] sel;
    logic       fs;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned checks = 0;
  int unsigned errors = 0;

  // Model state: cycles since reset release, displayed and staged data.
  int unsigned m_n    = 0;
  logic [23:0] m_act  = '0;
  logic [23:0] m_sh   = '0;
  logic        m_pend = 1'b0;

  function automatic exp_t model_out(int unsigned n, logic [23:0] act);
    exp_t        e;
    int unsigned p   = n % CD;
    int unsigned idx = (n / CD) % ND;
    bit          blanked = 1'b0;
`ifdef SEG_SCAN_LZB_EN
    if (idx > 0 && (act >> (4 * idx)) == 24'd0) blanked = 1'b1;
`endif
    e.bcd = blanked ? 4'd0 : 4'(act >> (4 * idx));
    e.sel = (p < DC || blanked) ? 6'h3F : (6'h3F ^ 6'(1 << idx));
    e.fs  = (n % FRAME) == 0;
    return e;
  endfunction

  // Reference model
  initial begin
    exp_t e;
    bit   at_wrap;
    forever begin
      @(posedge clk);
      if (rst) begin
        e.bcd = 4'd0; e.sel = 6'h3F; e.fs = 1'b0;
        exp_q.push_back(e);
        m_n = 0; m_act = '0; m_sh = '0; m_pend = 1'b0;
      end else begin
        exp_q.push_back(model_out(m_n, m_act));
        at_wrap = (m_n % FRAME) == FRAME - 1;
        if (bus.load) begin
          if (at_wrap) begin m_act = bus.digits_in; m_pend = 1'b0; end
          else         begin m_sh  = bus.digits_in; m_pend = 1'b1; end
        end else if (at_wrap && m_pend) begin
          m_act  = m_sh;
          m_pend = 1'b0;
        end
        m_n++;
      end
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("bcd_out",     32'(bus.bcd_out),     32'(e.bcd));
        chk("dig_sel",     32'(bus.dig_sel),     32'(e.sel));
        chk("frame_start", 32'(bus.frame_start), 32'(e.fs));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic run(int unsigned n);
    repeat (n) tick();
  endtask

  // Waits until the DUT state sampled at the next edge sits at frame phase ph.
  task automatic wait_phase(int unsigned ph);
    for (int k = 0; k < 4 * FRAME; k++) begin
      if ((m_n % FRAME) == ph) return;
      tick();
    end
    checks++;
    errors++;
    $display("FAIL wait_phase %0d: phase not reached, at %0d", ph, m_n % FRAME);
  endtask

  task automatic load_pulse(logic [23:0] d);
    bus.digits_in = d;
    bus.load      = 1'b1;
    tick();
    bus.load      = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    bus.digits_in = '0;
    bus.load      = 1'b0;
    rst           = 1'b1;
    run(3);
    rst = 1'b0;
    run(2 * FRAME + 4);                 // free-run scan of zeros

    wait_phase(20); load_pulse(24'h123456);
    run(2 * FRAME + 10);

    wait_phase(10); load_pulse(24'h111111);
    wait_phase(30); load_pulse(24'h222222);
    run(FRAME + 10);

    wait_phase(FRAME - 1); load_pulse(24'h000905);
    run(2 * FRAME);

    wait_phase(5); load_pulse(24'hFA0000);
    run(FRAME + 50);

    wait_phase(10); load_pulse(24'h777777);
    wait_phase(3 * CD + 5);
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    run(FRAME + 12);

    repeat (400) begin
      r = $urandom();
      r = r >> (4 * $urandom_range(0, 5));
      bus.digits_in = r[23:0];
      bus.load      = ($urandom_range(0, 15) == 0);
      rst           = ($urandom_range(0, 199) == 0);
      tick();
    end
    bus.load = 1'b0;
    rst      = 1'b0;
    run(FRAME);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
